// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - raster timing generator for the 480x272 TFT panel
module lcd_timing_gen #(
  parameter int H_SYNC     = 41,
  parameter int H_DE_START = 44,
  parameter int H_ACTIVE   = 480,
  parameter int H_TOTAL    = 528,
  parameter int V_SYNC     = 10,
  parameter int V_DE_START = 13,
  parameter int V_ACTIVE   = 272,
  parameter int V_TOTAL    = 288
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       de,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic       frame_tick,
  output logic       line_tick
);

  // Window bounds are kept 11 bits wide so a window ending exactly at 1024 still compares correctly.
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_SY    = 11'(H_SYNC);
  localparam logic [10:0] V_SY    = 11'(V_SYNC);
  localparam logic [10:0] H_DS    = 11'(H_DE_START);
  localparam logic [10:0] H_DE    = 11'(H_DE_START + H_ACTIVE);
  localparam logic [10:0] V_DS    = 11'(V_DE_START);
  localparam logic [10:0] V_DE    = 11'(V_DE_START + V_ACTIVE);
  localparam logic [10:0] V_BLANK = 11'(V_DE_START + V_ACTIVE);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       wrap;
  logic       de_nxt;
  logic [8:0] px_nxt;
  logic [8:0] py_nxt;
  logic       ft_nxt;

  // Next raster position and every level derived from it, so outputs never lag the counters.
  always_comb begin
    wrap   = 1'b0;
    h_nxt  = hcnt + 10'd1;
    v_nxt  = vcnt;
    if (hcnt == H_LAST) begin
      wrap  = 1'b1;
      h_nxt = '0;
      v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end
    de_nxt = ({1'b0, h_nxt} >= H_DS) && ({1'b0, h_nxt} < H_DE) &&
             ({1'b0, v_nxt} >= V_DS) && ({1'b0, v_nxt} < V_DE);
    px_nxt = de_nxt ? 9'({1'b0, h_nxt} - H_DS) : '0;
    py_nxt = de_nxt ? 9'({1'b0, v_nxt} - V_DS) : '0;
    ft_nxt = wrap && ({1'b0, v_nxt} == V_BLANK);
  end

  // Raster registers: reset wins over ce, ticks only fire on an advancing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      vcnt       <= '0;
      de         <= 1'b0;
      hsync_n    <= 1'b0;
      vsync_n    <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_tick <= 1'b0;
      line_tick  <= 1'b0;
    end else if (ce) begin
      hcnt       <= h_nxt;
      vcnt       <= v_nxt;
      de         <= de_nxt;
      hsync_n    <= !({1'b0, h_nxt} < H_SY);
      vsync_n    <= !({1'b0, v_nxt} < V_SY);
      pix_x      <= px_nxt;
      pix_y      <= py_nxt;
      frame_tick <= ft_nxt;
      line_tick  <= wrap;
    end else begin
      frame_tick <= 1'b0;
      line_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - self-checking bench for lcd_timing_gen
module tb_lcd_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;

  logic [9:0] hcnt0, vcnt0, hcnt1, vcnt1;
  logic       de0, hs0, vs0, ft0, lt0;
  logic       de1, hs1, vs1, ft1, lt1;
  logic [8:0] px0, py0, px1, py1;

  // Instance 0 uses the panel defaults; instance 1 is a shrunken raster so whole frames fit in the run.
  lcd_timing_gen dut0 (
    .clk(clk), .rst(rst), .ce(ce),
    .hcnt(hcnt0), .vcnt(vcnt0), .de(de0), .hsync_n(hs0), .vsync_n(vs0),
    .pix_x(px0), .pix_y(py0), .frame_tick(ft0), .line_tick(lt0)
  );

  lcd_timing_gen #(
    .H_SYNC(5), .H_DE_START(8), .H_ACTIVE(48), .H_TOTAL(64),
    .V_SYNC(2), .V_DE_START(3), .V_ACTIVE(18), .V_TOTAL(24)
  ) dut1 (
    .clk(clk), .rst(rst), .ce(ce),
    .hcnt(hcnt1), .vcnt(vcnt1), .de(de1), .hsync_n(hs1), .vsync_n(vs1),
    .pix_x(px1), .pix_y(py1), .frame_tick(ft1), .line_tick(lt1)
  );

  always #5 clk = ~clk;

  int HT [2] = '{528, 64};
  int VT [2] = '{288, 24};
  int HS [2] = '{41, 5};
  int VS [2] = '{10, 2};
  int HDS[2] = '{44, 8};
  int HA [2] = '{480, 48};
  int VDS[2] = '{13, 3};
  int VA [2] = '{272, 18};

  // Reference model: linear pixel index within the frame plus the expected tick levels.
  int   pos [2];
  logic lt_m[2];
  logic ft_m[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk(input int k, input logic [9:0] ha, input logic [9:0] va, input logic dea,
                     input logic hsa, input logic vsa, input logic [8:0] pxa, input logic [8:0] pya,
                     input logic fta, input logic lta);
    int   h, v;
    logic de_e;
    h    = pos[k] % HT[k];
    v    = pos[k] / HT[k];
    de_e = (h >= HDS[k]) && (h < HDS[k] + HA[k]) && (v >= VDS[k]) && (v < VDS[k] + VA[k]);
    cmp($sformatf("hcnt%0d", k), 32'(ha), 32'(h));
    cmp($sformatf("vcnt%0d", k), 32'(va), 32'(v));
    cmp($sformatf("de%0d", k), 32'(dea), 32'(de_e));
    cmp($sformatf("hsync_n%0d", k), 32'(hsa), 32'(h >= HS[k]));
    cmp($sformatf("vsync_n%0d", k), 32'(vsa), 32'(v >= VS[k]));
    cmp($sformatf("pix_x%0d", k), 32'(pxa), de_e ? 32'(h - HDS[k]) : 32'd0);
    cmp($sformatf("pix_y%0d", k), 32'(pya), de_e ? 32'(v - VDS[k]) : 32'd0);
    cmp($sformatf("frame_tick%0d", k), 32'(fta), 32'(ft_m[k]));
    cmp($sformatf("line_tick%0d", k), 32'(lta), 32'(lt_m[k]));
  endtask

  task automatic step(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        pos[k]  = 0;
        lt_m[k] = 1'b0;
        ft_m[k] = 1'b0;
      end else if (c) begin
        pos[k]  = (pos[k] + 1) % (HT[k] * VT[k]);
        lt_m[k] = (pos[k] % HT[k]) == 0;
        ft_m[k] = (pos[k] == (VDS[k] + VA[k]) * HT[k]);
      end else begin
        lt_m[k] = 1'b0;
        ft_m[k] = 1'b0;
      end
    end
    #1;
    chk(0, hcnt0, vcnt0, de0, hs0, vs0, px0, py0, ft0, lt0);
    chk(1, hcnt1, vcnt1, de1, hs1, vs1, px1, py1, ft1, lt1);
  endtask

  initial begin
    int last_lt0, last_lt1, last_ft1;
    int n;
    last_lt0 = -1;
    last_lt1 = -1;
    last_ft1 = -1;

    // Reset state, including reset winning over ce.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Continuous scan: default raster past the first active line, several small frames.
    for (int i = 0; i < 7800; i++) begin
      step(1'b0, 1'b1);
      if (lt0 === 1'b1) begin
        if (last_lt0 >= 0) cmp("line_period0", 32'(cyc - last_lt0), 32'd528);
        last_lt0 = cyc;
      end
      if (lt1 === 1'b1) begin
        if (last_lt1 >= 0) cmp("line_period1", 32'(cyc - last_lt1), 32'd64);
        last_lt1 = cyc;
      end
      if (ft1 === 1'b1) begin
        if (last_ft1 >= 0) cmp("frame_period1", 32'(cyc - last_ft1), 32'd1536);
        last_ft1 = cyc;
      end
    end
    cmp("frame_seen1", 32'(last_ft1 > 0), 32'd1);

    // ce on every 4th clock.
    for (int i = 0; i < 3200; i++) step(1'b0, (i % 4) == 0);

    // Reach the first blanking line of the small raster, then stall there.
    n = 0;
    while (!(ft1 === 1'b1) && n < 2000) begin
      step(1'b0, 1'b1);
      n++;
    end
    cmp("reach_frame_tick", 32'(ft1), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      cmp("stall_frame_tick", 32'(ft1), 32'd0);
    end
    cmp("stall_vcnt1", 32'(vcnt1), 32'd21);

    // Random ce with rare resets.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1);

    // Mid-frame reset, then normal restart.
    n = 0;
    while (!(hcnt1 === 10'd30 && vcnt1 === 10'd10) && n < 2000) begin
      step(1'b0, 1'b1);
      n++;
    end
    cmp("reach_mid_frame", 32'(hcnt1 == 10'd30 && vcnt1 == 10'd10), 32'd1);
    step(1'b1, 1'b1);
    cmp("mid_rst_de1", 32'(de1), 32'd0);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Generates raster timing for the 480x272 TFT LCD: horizontal/vertical counters, active-low syncs, data-enable, pixel coordinates and a per-frame tick.
- Drives the hcnt/vcnt/de bus consumed by the paddle, ball and score draw blocks.
- Drives the move_en strobe used by the game-logic blocks.
- Its DE window is fixed so that hDE is high for hcnt 44..523 and vDE is high for vcnt 13..284, matching the CORR_X=43 / CORR_Y=12 offsets used by all draw blocks.

Parameters:
- H_SYNC, 41, hsync_n low width in pixel clocks (hcnt 0..40)
- H_DE_START, 44, first hcnt with horizontal DE high
- H_ACTIVE, 480, active pixels per line
- H_TOTAL, 528, pixel clocks per line (hcnt 0..527)
- V_SYNC, 10, vsync_n low width in lines (vcnt 0..9)
- V_DE_START, 13, first vcnt with vertical DE high
- V_ACTIVE, 272, active lines per frame
- V_TOTAL, 288, lines per frame (vcnt 0..287)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ce  input  1  pixel-clock enable; the raster advances one pixel per clk with ce=1
- hcnt  output  10  horizontal counter, 0..H_TOTAL-1
- vcnt  output  10  vertical counter, 0..V_TOTAL-1
- de  output  1  data enable
- hsync_n  output  1  horizontal sync, active-low
- vsync_n  output  1  vertical sync, active-low
- pix_x  output  9  active-area column (hcnt-H_DE_START) while de=1, else 0
- pix_y  output  9  active-area row (vcnt-V_DE_START) while de=1, else 0
- frame_tick  output  1  one-clk pulse at start of vertical blanking (move_en source)
- line_tick  output  1  one-clk pulse on each hcnt wrap

Behaviour:
- Reset and register rules:
  - One clock, one synchronous active-high reset; rst has priority over ce.
  - All outputs are registers, and no output is a combinational function of inputs.
  - Reset values: hcnt=0, vcnt=0, de=0, hsync_n=0, vsync_n=0, pix_x=0, pix_y=0, frame_tick=0, line_tick=0.
  - The first cycle after rst deasserts with ce=1 moves hcnt to 1.
- Counters:
  - On a clk edge with ce=1: if hcnt==H_TOTAL-1, then hcnt<=0.
  - In that same wrap case: vcnt<=(vcnt==V_TOTAL-1)?0:vcnt+1.
  - Otherwise hcnt<=hcnt+1 and vcnt is held.
  - With ce=0 all counters and derived levels hold.
- Consistency invariant: every derived level output is registered together with the counters, so in every cycle each of the following holds:
  - de == (H_DE_START<=hcnt<=H_DE_START+H_ACTIVE-1) && (V_DE_START<=vcnt<=V_DE_START+V_ACTIVE-1). With defaults, hcnt 44..523 and vcnt 13..284.
  - hsync_n == !(hcnt<H_SYNC)
  - vsync_n == !(vcnt<V_SYNC)
  - pix_x == de ? hcnt-H_DE_START : 0
  - pix_y == de ? vcnt-V_DE_START : 0
  - The implementation computes next-state values from the next counter values; no one-cycle lag is allowed.
- Arithmetic:
  - The 10-bit counters never exceed H_TOTAL-1 or V_TOTAL-1.
  - pix_x and pix_y are truncated to 9 bits; they cannot overflow for the defaults (max 479 and 271).
- Ticks:
  - line_tick=1 for exactly the one clk cycle in which the counters newly show hcnt=0 (after a wrap). It is 0 otherwise, including ce=0 stall cycles and reset.
  - frame_tick=1 for exactly the one clk cycle in which the counters newly show hcnt=0, vcnt=V_DE_START+V_ACTIVE (285). This is the first line after the last active line.
  - Both ticks are qualified by the transition, not by the level. A ce=0 stall at that position must not stretch a tick.
- Reset mid-frame: counters return to (0,0) on the next edge. A tick pending that cycle is suppressed, and de drops immediately on that edge.
- No parameter checking in RTL.
- Parameters are legal only when:
  - H_DE_START+H_ACTIVE<=H_TOTAL and V_DE_START+V_ACTIVE<=V_TOTAL.
  - H_SYNC<=H_DE_START and V_SYNC<=V_DE_START.
  - H_TOTAL and V_TOTAL are <=1024.

Test Plan:
- Reset, then ce=1 continuously for 1 frame -> exactly 528*288=152064 clks between consecutive frame_tick pulses; line_tick period 528.
- Line scan at vcnt=13 -> de rises with hcnt=44 (pix_x=0, pix_y=0) and falls after hcnt=523 (pix_x=479); de=0 at hcnt=43 and 524.
- Frame scan -> de never high for vcnt<13 or >284; at vcnt=284, hcnt=523: de=1, pix_x=479, pix_y=271.
- Sync widths -> hsync_n low exactly for hcnt 0..40 on every line; vsync_n low exactly for vcnt 0..9.
- ce=1 every 4th clk -> counters step once per ce, and line_tick/frame_tick stay 1 clk wide. Stall ce=0 for 10 clks at hcnt=0, vcnt=285 -> frame_tick high only on the first of those cycles.
- Assert rst for 1 clk at hcnt=300, vcnt=100 -> next cycle hcnt=0, vcnt=0, de=0, hsync_n=0, vsync_n=0, ticks 0; the raster then restarts normally.
